// File: rtl/tl_ul_link_buffer.sv
// TileLink-UL link buffer: circular queues on the A and D channels plus an
// outstanding-request counter that throttles A when the in-flight limit is reached.

module tl_ul_link_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int LIMIT = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enq_valid_i,
  output logic         enq_ready_o,
  input  logic [W-1:0] enq_data_i,
  input  logic [2:0]   extra_i,
  output logic         deq_valid_o,
  input  logic         deq_ready_i,
  output logic [W-1:0] deq_data_o,
  output logic [2:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]    count_q, count_d;
  logic          empty, enq_fire, deq_fire, bypass, do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty       = (count_q == 3'd0);
    // extra_i + count is checked against LIMIT so the A side can reserve in-flight slots
    enq_ready_o = (count_q < 3'(DEPTH)) &&
                  (({1'b0, count_q} + {1'b0, extra_i}) < 4'(LIMIT));
    enq_fire    = enq_valid_i && enq_ready_o;
    if ((FLOW != 0) && empty) begin
      deq_valid_o = enq_fire;
      deq_data_o  = enq_data_i;
    end else begin
      deq_valid_o = !empty;
      deq_data_o  = mem_q[rptr_q];
    end
    deq_fire = deq_valid_o && deq_ready_i;
    bypass   = (FLOW != 0) && empty && deq_fire;
    do_wr    = enq_fire && !bypass;
    do_rd    = deq_fire && !bypass;
    wptr_d   = do_wr ? ptr_inc(wptr_q) : wptr_q;
    rptr_d   = do_rd ? ptr_inc(rptr_q) : rptr_q;
    count_d  = count_q + 3'(do_wr) - 3'(do_rd);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 3'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wptr_q] <= enq_data_i;
  end

  assign count_o = count_q;

endmodule

module tl_ul_link_buffer #(
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int FLOW     = 0,
  parameter int MAX_INFL = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_in_valid,
  output logic        a_in_ready,
  input  logic [2:0]  a_in_opcode,
  input  logic [2:0]  a_in_param,
  input  logic [1:0]  a_in_size,
  input  logic [1:0]  a_in_source,
  input  logic [11:0] a_in_address,
  input  logic [3:0]  a_in_mask,
  input  logic [31:0] a_in_data,
  output logic        a_out_valid,
  input  logic        a_out_ready,
  output logic [2:0]  a_out_opcode,
  output logic [2:0]  a_out_param,
  output logic [1:0]  a_out_size,
  output logic [1:0]  a_out_source,
  output logic [11:0] a_out_address,
  output logic [3:0]  a_out_mask,
  output logic [31:0] a_out_data,
  input  logic        d_in_valid,
  output logic        d_in_ready,
  input  logic [2:0]  d_in_opcode,
  input  logic [1:0]  d_in_param,
  input  logic [1:0]  d_in_size,
  input  logic [1:0]  d_in_source,
  input  logic        d_in_sink,
  input  logic        d_in_denied,
  input  logic        d_in_corrupt,
  input  logic [31:0] d_in_data,
  output logic        d_out_valid,
  input  logic        d_out_ready,
  output logic [2:0]  d_out_opcode,
  output logic [1:0]  d_out_param,
  output logic [1:0]  d_out_size,
  output logic [1:0]  d_out_source,
  output logic        d_out_sink,
  output logic        d_out_denied,
  output logic        d_out_corrupt,
  output logic [31:0] d_out_data,
  output logic [2:0]  inflight,
  output logic        infl_underflow
);

  localparam int AW = 58;
  localparam int DW = 44;

  logic [AW-1:0] a_enq_data, a_deq_data;
  logic [DW-1:0] d_enq_data, d_deq_data;
  logic [2:0]    a_count, d_count_unused_guard;
  logic [2:0]    inflight_q, inflight_d;
  logic          underflow_q, underflow_d;
  logic          a_out_fire, d_in_fire;

  assign a_enq_data = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                       a_in_address, a_in_mask, a_in_data};
  assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
          a_out_address, a_out_mask, a_out_data} = a_deq_data;
  assign d_enq_data = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                       d_in_sink, d_in_denied, d_in_corrupt, d_in_data};
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
          d_out_sink, d_out_denied, d_out_corrupt, d_out_data} = d_deq_data;

  tl_ul_link_queue #(.W(AW), .DEPTH(A_DEPTH), .FLOW(FLOW), .LIMIT(MAX_INFL)) u_a_queue (
    .clock       (clock),
    .reset       (reset),
    .enq_valid_i (a_in_valid),
    .enq_ready_o (a_in_ready),
    .enq_data_i  (a_enq_data),
    .extra_i     (inflight_q),
    .deq_valid_o (a_out_valid),
    .deq_ready_i (a_out_ready),
    .deq_data_o  (a_deq_data),
    .count_o     (a_count)
  );

  // D side has no in-flight reservation: LIMIT above any reachable count
  tl_ul_link_queue #(.W(DW), .DEPTH(D_DEPTH), .FLOW(FLOW), .LIMIT(8)) u_d_queue (
    .clock       (clock),
    .reset       (reset),
    .enq_valid_i (d_in_valid),
    .enq_ready_o (d_in_ready),
    .enq_data_i  (d_enq_data),
    .extra_i     (d_count_unused_guard),
    .deq_valid_o (d_out_valid),
    .deq_ready_i (d_out_ready),
    .deq_data_o  (d_deq_data),
    .count_o     (d_count_unused_guard)
  );

  assign a_out_fire = a_out_valid && a_out_ready;
  assign d_in_fire  = d_in_valid && d_in_ready;

  always_comb begin
    inflight_d  = inflight_q;
    underflow_d = underflow_q;
    if (d_in_fire && (inflight_q == 3'd0)) underflow_d = 1'b1;
    if (a_out_fire && !d_in_fire) begin
      inflight_d = inflight_q + 3'd1;
    end else if (d_in_fire && !a_out_fire && (inflight_q != 3'd0)) begin
      inflight_d = inflight_q - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q  <= 3'd0;
      underflow_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  assign inflight       = inflight_q;
  assign infl_underflow = underflow_q;

  logic unused_a_count;
  assign unused_a_count = ^a_count;

endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Bench for tl_ul_link_buffer: directed table and sequences plus a randomized
// run checked against a queue-based reference model.

module tb_tl_ul_link_buffer;

  localparam int A_DEPTH  = 2;
  localparam int D_DEPTH  = 2;
  localparam int MAX_INFL = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        a_in_valid, a_out_ready, d_in_valid, d_out_ready;
  logic [2:0]  a_in_opcode, a_in_param;
  logic [1:0]  a_in_size, a_in_source;
  logic [11:0] a_in_address;
  logic [3:0]  a_in_mask;
  logic [31:0] a_in_data;
  logic [2:0]  d_in_opcode;
  logic [1:0]  d_in_param, d_in_size, d_in_source;
  logic        d_in_sink, d_in_denied, d_in_corrupt;
  logic [31:0] d_in_data;

  logic        a_in_ready, a_out_valid, d_in_ready, d_out_valid, infl_underflow;
  logic [2:0]  a_out_opcode, a_out_param, d_out_opcode, inflight;
  logic [1:0]  a_out_size, a_out_source, d_out_param, d_out_size, d_out_source;
  logic [11:0] a_out_address;
  logic [3:0]  a_out_mask;
  logic [31:0] a_out_data, d_out_data;
  logic        d_out_sink, d_out_denied, d_out_corrupt;

  logic        f_a_in_ready, f_a_out_valid, f_d_in_ready, f_d_out_valid, f_infl_underflow;
  logic [2:0]  f_a_out_opcode, f_a_out_param, f_d_out_opcode, f_inflight;
  logic [1:0]  f_a_out_size, f_a_out_source, f_d_out_param, f_d_out_size, f_d_out_source;
  logic [11:0] f_a_out_address;
  logic [3:0]  f_a_out_mask;
  logic [31:0] f_a_out_data, f_d_out_data;
  logic        f_d_out_sink, f_d_out_denied, f_d_out_corrupt;

  tl_ul_link_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .FLOW(0), .MAX_INFL(MAX_INFL)) dut (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in_opcode(a_in_opcode),
    .a_in_param(a_in_param), .a_in_size(a_in_size), .a_in_source(a_in_source),
    .a_in_address(a_in_address), .a_in_mask(a_in_mask), .a_in_data(a_in_data),
    .a_out_valid(a_out_valid), .a_out_ready(a_out_ready), .a_out_opcode(a_out_opcode),
    .a_out_param(a_out_param), .a_out_size(a_out_size), .a_out_source(a_out_source),
    .a_out_address(a_out_address), .a_out_mask(a_out_mask), .a_out_data(a_out_data),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready), .d_in_opcode(d_in_opcode),
    .d_in_param(d_in_param), .d_in_size(d_in_size), .d_in_source(d_in_source),
    .d_in_sink(d_in_sink), .d_in_denied(d_in_denied), .d_in_corrupt(d_in_corrupt),
    .d_in_data(d_in_data),
    .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .d_out_opcode(d_out_opcode),
    .d_out_param(d_out_param), .d_out_size(d_out_size), .d_out_source(d_out_source),
    .d_out_sink(d_out_sink), .d_out_denied(d_out_denied), .d_out_corrupt(d_out_corrupt),
    .d_out_data(d_out_data),
    .inflight(inflight), .infl_underflow(infl_underflow)
  );

  tl_ul_link_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .FLOW(1), .MAX_INFL(MAX_INFL)) dut_flow (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(f_a_in_ready), .a_in_opcode(a_in_opcode),
    .a_in_param(a_in_param), .a_in_size(a_in_size), .a_in_source(a_in_source),
    .a_in_address(a_in_address), .a_in_mask(a_in_mask), .a_in_data(a_in_data),
    .a_out_valid(f_a_out_valid), .a_out_ready(a_out_ready), .a_out_opcode(f_a_out_opcode),
    .a_out_param(f_a_out_param), .a_out_size(f_a_out_size), .a_out_source(f_a_out_source),
    .a_out_address(f_a_out_address), .a_out_mask(f_a_out_mask), .a_out_data(f_a_out_data),
    .d_in_valid(d_in_valid), .d_in_ready(f_d_in_ready), .d_in_opcode(d_in_opcode),
    .d_in_param(d_in_param), .d_in_size(d_in_size), .d_in_source(d_in_source),
    .d_in_sink(d_in_sink), .d_in_denied(d_in_denied), .d_in_corrupt(d_in_corrupt),
    .d_in_data(d_in_data),
    .d_out_valid(f_d_out_valid), .d_out_ready(d_out_ready), .d_out_opcode(f_d_out_opcode),
    .d_out_param(f_d_out_param), .d_out_size(f_d_out_size), .d_out_source(f_d_out_source),
    .d_out_sink(f_d_out_sink), .d_out_denied(f_d_out_denied), .d_out_corrupt(f_d_out_corrupt),
    .d_out_data(f_d_out_data),
    .inflight(f_inflight), .infl_underflow(f_infl_underflow)
  );

  logic [57:0] a_in_pk, a_out_pk;
  logic [43:0] d_in_pk, d_out_pk;
  assign a_in_pk  = {a_in_opcode, a_in_param, a_in_size, a_in_source, a_in_address, a_in_mask, a_in_data};
  assign a_out_pk = {a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address, a_out_mask, a_out_data};
  assign d_in_pk  = {d_in_opcode, d_in_param, d_in_size, d_in_source, d_in_sink, d_in_denied, d_in_corrupt, d_in_data};
  assign d_out_pk = {d_out_opcode, d_out_param, d_out_size, d_out_source, d_out_sink, d_out_denied, d_out_corrupt, d_out_data};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [57:0] p);
    a_in_valid = v;
    {a_in_opcode, a_in_param, a_in_size, a_in_source, a_in_address, a_in_mask, a_in_data} = p;
  endtask

  task automatic drive_d(input logic v, input logic [43:0] p);
    d_in_valid = v;
    {d_in_opcode, d_in_param, d_in_size, d_in_source, d_in_sink, d_in_denied, d_in_corrupt, d_in_data} = p;
  endtask

  function automatic logic [57:0] get_beat(input logic [11:0] addr, input logic [1:0] src);
    return {3'd4, 3'd0, 2'd2, src, addr, 4'hF, 32'h0};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    drive_a(1'b0, '0);
    drive_d(1'b0, '0);
    a_out_ready = 1'b0;
    d_out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       av, aor, dv, dor;
    logic       e_ar, e_ov, e_dr, e_dv;
    logic [2:0] e_infl;
    logic       e_uf;
  } vec_t;

  vec_t tbl[10];

  // reference model state
  logic [57:0] qa[$];
  logic [43:0] qd[$];
  int          m_infl;
  logic        m_uf;

  initial begin
    // A-limit walk: four Gets fill the in-flight budget, one D beat frees a slot
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};

    do_reset();
    #1;
    check("reset_state", 64'({a_in_ready, a_out_valid, d_in_ready, d_out_valid, inflight, infl_underflow}),
          64'({1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0}));

    // single Get
    @(negedge clock);
    drive_a(1'b1, get_beat(12'h0A4, 2'd1));
    a_out_ready = 1'b1;
    #1 check("get_lat0_valid", 64'(a_out_valid), 64'd0);
    @(negedge clock);
    drive_a(1'b0, '0);
    #1 check("get_out", 64'({a_out_valid, a_out_opcode, a_out_address, a_out_source}),
             64'({1'b1, 3'd4, 12'h0A4, 2'd1}));
    @(negedge clock);
    #1 check("get_inflight", 64'({a_out_valid, inflight}), 64'({1'b0, 3'd1}));

    // backpressure, full-queue no-pipe, order
    do_reset();
    drive_a(1'b1, get_beat(12'h100, 2'd0));
    #1 check("bp_rdy1", 64'(a_in_ready), 64'd1);
    @(negedge clock);
    drive_a(1'b1, get_beat(12'h200, 2'd1));
    #1 check("bp_rdy2", 64'(a_in_ready), 64'd1);
    @(negedge clock);
    drive_a(1'b1, get_beat(12'h300, 2'd2));
    #1 check("bp_full", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    #1 check("full_deq_noenq", 64'({a_in_ready, a_out_valid, a_out_address}), 64'({1'b0, 1'b1, 12'h100}));
    @(negedge clock);
    #1 check("order_beat2", 64'({a_in_ready, a_out_valid, a_out_address}), 64'({1'b1, 1'b1, 12'h200}));
    @(negedge clock);
    drive_a(1'b0, '0);
    #1 check("order_beat3", 64'({a_out_valid, a_out_address, a_out_source}), 64'({1'b1, 12'h300, 2'd2}));
    @(negedge clock);
    #1 check("bp_drain", 64'({a_out_valid, inflight}), 64'({1'b0, 3'd3}));

    // in-flight limit table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_a(tbl[i].av, get_beat(12'(i), 2'(i)));
      a_out_ready = tbl[i].aor;
      drive_d(tbl[i].dv, {3'd1, 2'd0, 2'd2, 2'(i), 1'b0, 1'b0, 1'b0, 32'(i)});
      d_out_ready = tbl[i].dor;
      #1 check($sformatf("tbl_row%0d", i),
               64'({a_in_ready, a_out_valid, d_in_ready, d_out_valid, inflight, infl_underflow}),
               64'({tbl[i].e_ar, tbl[i].e_ov, tbl[i].e_dr, tbl[i].e_dv, tbl[i].e_infl, tbl[i].e_uf}));
      @(negedge clock);
    end

    // FLOW=1 zero-latency D path
    do_reset();
    drive_d(1'b1, {3'd1, 2'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
    d_out_ready = 1'b1;
    #1 check("flow_same_cycle", 64'({f_d_out_valid, f_d_in_ready, f_d_out_source, f_d_out_data}),
             64'({1'b1, 1'b1, 2'd2, 32'hDEADBEEF}));
    check("noflow_not_same_cycle", 64'(d_out_valid), 64'd0);
    @(negedge clock);
    drive_d(1'b0, '0);
    #1 check("flow_count_zero", 64'(f_d_out_valid), 64'd0);
    check("noflow_next_cycle", 64'({d_out_valid, d_out_data}), 64'({1'b1, 32'hDEADBEEF}));

    // underflow sticky, reset mid-transfer
    do_reset();
    drive_d(1'b1, {3'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 32'h1});
    @(negedge clock);
    drive_d(1'b0, '0);
    #1 check("underflow_set", 64'({infl_underflow, inflight}), 64'({1'b1, 3'd0}));
    drive_a(1'b1, get_beat(12'h044, 2'd3));
    drive_d(1'b1, {3'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 32'h2});
    @(negedge clock);
    #1 check("underflow_sticky", 64'({infl_underflow, a_out_valid, d_out_valid}), 64'({1'b1, 1'b1, 1'b1}));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    drive_a(1'b0, '0);
    drive_d(1'b0, '0);
    #1 check("reset_mid", 64'({a_out_valid, d_out_valid, infl_underflow, inflight, a_in_ready, d_in_ready}),
             64'({1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1}));

    // randomized run against the queue model
    do_reset();
    qa.delete();
    qd.delete();
    m_infl = 0;
    m_uf   = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        ea_rdy, ea_v, ed_rdy, ed_v, a_enq, a_deq, d_enq, d_deq;
      logic [57:0] ea_pk;
      logic [43:0] ed_pk;
      int          bias;
      bias = (cyc / 500) % 4;
      reset = ($urandom_range(0, 299) == 0);
      drive_a($urandom_range(0, 3) != 0, {$urandom(), $urandom()});
      drive_d($urandom_range(0, 3) == 0, {$urandom(), $urandom()});
      a_out_ready = ($urandom_range(0, 3) < 32'(bias + 1));
      d_out_ready = ($urandom_range(0, 3) < 32'(4 - bias));
      #1;
      ea_rdy = (qa.size() < A_DEPTH) && (m_infl + qa.size() < MAX_INFL);
      ea_v   = (qa.size() != 0);
      ed_rdy = (qd.size() < D_DEPTH);
      ed_v   = (qd.size() != 0);
      ea_pk  = '0;
      ed_pk  = '0;
      if (ea_v) ea_pk = qa[0];
      if (ed_v) ed_pk = qd[0];
      check("rnd_a", 64'({a_in_ready, a_out_valid, a_out_valid ? a_out_pk : 58'd0}), 64'({ea_rdy, ea_v, ea_pk}));
      check("rnd_d", 64'({d_in_ready, d_out_valid, d_out_valid ? d_out_pk : 44'd0}), 64'({ed_rdy, ed_v, ed_pk}));
      check("rnd_cnt", 64'({inflight, infl_underflow}), 64'({3'(m_infl), m_uf}));
      a_enq = a_in_valid && ea_rdy;
      a_deq = ea_v && a_out_ready;
      d_enq = d_in_valid && ed_rdy;
      d_deq = ed_v && d_out_ready;
      if (reset) begin
        qa.delete();
        qd.delete();
        m_infl = 0;
        m_uf   = 1'b0;
      end else begin
        if (a_deq) void'(qa.pop_front());
        if (a_enq) qa.push_back(a_in_pk);
        if (d_deq) void'(qd.pop_front());
        if (d_enq) qd.push_back(d_in_pk);
        if (d_enq && m_infl == 0) m_uf = 1'b1;
        if (a_deq && !d_enq) m_infl++;
        else if (d_enq && !a_deq && m_infl > 0) m_infl--;
      end
      @(negedge clock);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
